// File: rtl/iob_fp_mul_stream.sv
// Streaming floating-point multiplier with four pipeline stages.
// The stages are unpack/classify, mantissa multiply with exponent add, normalise,
// and round/pack into the output registers. One advance enable moves every stage
// at once. Subnormal inputs are flushed to zero and subnormal results are never produced.
module iob_fp_mul_stream #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] res_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              invalid_o,
  output logic              inexact_o
);

  localparam int F  = DATA_W - EXP_W - 1;
  localparam int EW = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [EW-1:0] BIAS_X = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};

  // Global advance: the pipeline moves whenever the output slot is free or being drained.
  logic w_en;
  assign w_en    = ~valid_o | ready_i;
  assign ready_o = w_en;

  // ---------------- stage 1: unpack / classify ----------------
  logic             w_a_sign, w_b_sign, w_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [F-1:0]     w_a_frac, w_b_frac;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic             w_spec, w_spec_inv;
  logic [DATA_W-1:0] w_spec_res;

  assign {w_a_sign, w_a_exp, w_a_frac} = op_a_i;
  assign {w_b_sign, w_b_exp, w_b_frac} = op_b_i;
  assign w_sign   = w_a_sign ^ w_b_sign;
  assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
  assign w_b_nan  = (&w_b_exp) & (|w_b_frac);
  assign w_a_inf  = (&w_a_exp) & ~(|w_a_frac);
  assign w_b_inf  = (&w_b_exp) & ~(|w_b_frac);
  // A zero exponent covers both true zeros and flushed subnormals.
  assign w_a_zero = ~(|w_a_exp);
  assign w_b_zero = ~(|w_b_exp);

  // Special-case result selection in priority order: NaN, inf*0, inf, zero.
  always_comb begin
    w_spec     = 1'b0;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (w_a_nan | w_b_nan) begin
      w_spec     = 1'b1;
      w_spec_inv = 1'b1;
      w_spec_res = QNAN;
    end else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
      w_spec     = 1'b1;
      w_spec_inv = 1'b1;
      w_spec_res = QNAN;
    end else if (w_a_inf | w_b_inf) begin
      w_spec     = 1'b1;
      w_spec_res = {w_sign, {EXP_W{1'b1}}, {F{1'b0}}};
    end else if (w_a_zero | w_b_zero) begin
      w_spec     = 1'b1;
      w_spec_res = {w_sign, {(DATA_W-1){1'b0}}};
    end
  end

  logic              r_s1_valid, r_s1_sign, r_s1_spec, r_s1_spec_inv;
  logic [EXP_W-1:0]  r_s1_ea, r_s1_eb;
  logic [F:0]        r_s1_ma, r_s1_mb;
  logic [DATA_W-1:0] r_s1_spec_res;

  // Stage 1 register: capture classified operands with hidden bits attached.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid    <= 1'b0;
      r_s1_sign     <= 1'b0;
      r_s1_spec     <= 1'b0;
      r_s1_spec_inv <= 1'b0;
      r_s1_ea       <= '0;
      r_s1_eb       <= '0;
      r_s1_ma       <= '0;
      r_s1_mb       <= '0;
      r_s1_spec_res <= '0;
    end else if (w_en) begin
      r_s1_valid    <= valid_i;
      r_s1_sign     <= w_sign;
      r_s1_spec     <= w_spec;
      r_s1_spec_inv <= w_spec_inv;
      r_s1_ea       <= w_a_exp;
      r_s1_eb       <= w_b_exp;
      r_s1_ma       <= {1'b1, w_a_frac};
      r_s1_mb       <= {1'b1, w_b_frac};
      r_s1_spec_res <= w_spec_res;
    end
  end

  // ---------------- stage 2: multiply / exponent add ----------------
  logic [2*F+1:0] w_prod;
  logic [EW-1:0]  w_s2_exp;
  assign w_prod   = {{(F+1){1'b0}}, r_s1_ma} * {{(F+1){1'b0}}, r_s1_mb};
  // Two extra exponent bits keep ea+eb-bias from wrapping at either extreme.
  assign w_s2_exp = {2'b00, r_s1_ea} + {2'b00, r_s1_eb} - BIAS_X;

  logic                  r_s2_valid, r_s2_sign, r_s2_spec, r_s2_spec_inv;
  logic signed [EW-1:0]  r_s2_exp;
  logic [2*F+1:0]        r_s2_prod;
  logic [DATA_W-1:0]     r_s2_spec_res;

  // Stage 2 register: raw product and biased exponent sum.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s2_valid    <= 1'b0;
      r_s2_sign     <= 1'b0;
      r_s2_spec     <= 1'b0;
      r_s2_spec_inv <= 1'b0;
      r_s2_exp      <= '0;
      r_s2_prod     <= '0;
      r_s2_spec_res <= '0;
    end else if (w_en) begin
      r_s2_valid    <= r_s1_valid;
      r_s2_sign     <= r_s1_sign;
      r_s2_spec     <= r_s1_spec;
      r_s2_spec_inv <= r_s1_spec_inv;
      r_s2_exp      <= w_s2_exp;
      r_s2_prod     <= w_prod;
      r_s2_spec_res <= r_s1_spec_res;
    end
  end

  // ---------------- stage 3: normalise ----------------
  logic           w_s3_msb;
  logic [2*F+1:0] w_norm;
  logic [EW-1:0]  w_s3_exp;
  assign w_s3_msb = r_s2_prod[2*F+1];
  // Product of two [1,2) mantissas lies in [1,4): at most one left shift aligns it.
  assign w_norm   = w_s3_msb ? r_s2_prod : {r_s2_prod[2*F:0], 1'b0};
  assign w_s3_exp = r_s2_exp + {{(EW-1){1'b0}}, w_s3_msb};

  logic                  r_s3_valid, r_s3_sign, r_s3_spec, r_s3_spec_inv;
  logic                  r_s3_g, r_s3_r, r_s3_s;
  logic signed [EW-1:0]  r_s3_exp;
  logic [F:0]            r_s3_mant;
  logic [DATA_W-1:0]     r_s3_spec_res;

  // Stage 3 register: kept mantissa plus guard, round and sticky bits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s3_valid    <= 1'b0;
      r_s3_sign     <= 1'b0;
      r_s3_spec     <= 1'b0;
      r_s3_spec_inv <= 1'b0;
      r_s3_g        <= 1'b0;
      r_s3_r        <= 1'b0;
      r_s3_s        <= 1'b0;
      r_s3_exp      <= '0;
      r_s3_mant     <= '0;
      r_s3_spec_res <= '0;
    end else if (w_en) begin
      r_s3_valid    <= r_s2_valid;
      r_s3_sign     <= r_s2_sign;
      r_s3_spec     <= r_s2_spec;
      r_s3_spec_inv <= r_s2_spec_inv;
      r_s3_g        <= w_norm[F];
      r_s3_r        <= w_norm[F-1];
      r_s3_s        <= |w_norm[F-2:0];
      r_s3_exp      <= w_s3_exp;
      r_s3_mant     <= w_norm[2*F+1:F+1];
      r_s3_spec_res <= r_s2_spec_res;
    end
  end

  // ---------------- stage 4: round / pack ----------------
  logic                 w_inc, w_carry, w_rnd_inx;
  logic [F+1:0]         w_mant_rnd;
  logic signed [EW-1:0] w_exp_rnd;
  logic [F-1:0]         w_frac;
  assign w_inc      = r_s3_g & (r_s3_r | r_s3_s | r_s3_mant[0]);
  assign w_mant_rnd = {1'b0, r_s3_mant} + {{(F+1){1'b0}}, w_inc};
  assign w_carry    = w_mant_rnd[F+1];
  assign w_exp_rnd  = r_s3_exp + {{(EW-1){1'b0}}, w_carry};
  // On carry-out the mantissa is exactly 10.00..0, so the shifted fraction is all zeros.
  assign w_frac     = w_carry ? w_mant_rnd[F:1] : w_mant_rnd[F-1:0];
  assign w_rnd_inx  = r_s3_g | r_s3_r | r_s3_s;

  logic [DATA_W-1:0] w_res;
  logic              w_ovf, w_unf, w_inv, w_inx;

  // Final result selection: special case, exponent overflow, underflow, or normal.
  always_comb begin
    w_res = {r_s3_sign, w_exp_rnd[EXP_W-1:0], w_frac};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    w_inx = w_rnd_inx;
    if (r_s3_spec) begin
      w_res = r_s3_spec_res;
      w_inv = r_s3_spec_inv;
      w_inx = 1'b0;
    end else if (w_exp_rnd >= EXP_MAX) begin
      w_res = {r_s3_sign, {EXP_W{1'b1}}, {F{1'b0}}};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_exp_rnd <= EXP_ZERO) begin
      w_res = {r_s3_sign, {(DATA_W-1){1'b0}}};
      w_unf = 1'b1;
      w_inx = 1'b1;
    end
  end

  logic              r_valid, r_ovf, r_unf, r_inv, r_inx;
  logic [DATA_W-1:0] r_res;

  // Output registers: result and its flags move together, so stalls keep them aligned.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_inv   <= 1'b0;
      r_inx   <= 1'b0;
    end else if (w_en) begin
      r_valid <= r_s3_valid;
      r_res   <= w_res;
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
      r_inv   <= w_inv;
      r_inx   <= w_inx;
    end
  end

  assign valid_o     = r_valid;
  assign res_o       = r_res;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_unf;
  assign invalid_o   = r_inv;
  assign inexact_o   = r_inx;

endmodule

// File: tb/tb_iob_fp_mul_stream.sv
// Scoreboard bench for iob_fp_mul_stream (single-precision configuration).
module tb_iob_fp_mul_stream;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] op_a_i, op_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] res_o;
  logic        overflow_o, underflow_o, invalid_o, inexact_o;

  iob_fp_mul_stream #(.DATA_W(32), .EXP_W(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .res_o       (res_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .invalid_o   (invalid_o),
    .inexact_o   (inexact_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_pop   = 0;
  int   cyc     = 0;
  bit   chk_lat = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference model, flags packed as {overflow, underflow, invalid, inexact}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s, inx;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [63:0] p, q, rem, half;
    int          e, sh;
    bit na, nb, ia, ib, za, zb;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    na = (ea == 8'hFF) && (fa != 0); nb = (eb == 8'hFF) && (fb != 0);
    ia = (ea == 8'hFF) && (fa == 0); ib = (eb == 8'hFF) && (fb == 0);
    za = (ea == 0); zb = (eb == 0);
    if (na || nb) return {4'b0010, 32'h7FC00000};
    if ((ia && zb) || (za && ib)) return {4'b0010, 32'h7FC00000};
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
    if (za || zb) return {4'b0000, s, 31'd0};
    p = {40'd0, 1'b1, fa} * {40'd0, 1'b1, fb};
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin sh = 24; e = e + 1; end
    else sh = 23;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return {4'b1001, s, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0101, s, 31'd0};
    return {3'b000, inx, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [22:0] f;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom_range(0, 11))
      0:       return {s, 8'h00, 23'd0};
      1:       return {s, 8'h00, f};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, f | 23'd1};
      4:       return {s, 8'($urandom_range(190, 254)), f};
      5:       return {s, 8'($urandom_range(1, 64)), f};
      6:       return {s, 8'd127, 23'($urandom_range(0, 7))};
      default: return {s, 8'($urandom_range(100, 154)), f};
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, then observe the handshakes
  // that the next rising edge will complete.
  task automatic drive_cycle(input logic vi, input logic [31:0] a, input logic [31:0] b,
                             input logic ri, input logic [35:0] expv, output logic acc);
    exp_t e;
    @(negedge clk_i);
    valid_i = vi; op_a_i = a; op_b_i = b; ready_i = ri;
    #1;
    if (valid_o) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", 64'(valid_o), 64'd0);
      end else if (ready_i) begin
        e = sb.pop_front();
        check_val("res", 64'(res_o), 64'(e.res));
        check_val("flags", 64'({overflow_o, underflow_o, invalid_o, inexact_o}), 64'(e.flg));
        if (chk_lat) check_val("latency", 64'(cyc - e.acc), 64'd4);
        n_pop++;
        $display("txn a=%h b=%h res=%h flags=%b", e.a, e.b, res_o,
                 {overflow_o, underflow_o, invalid_o, inexact_o});
      end else begin
        check_val("stall_res", 64'(res_o), 64'(sb[0].res));
        check_val("stall_flags", 64'({overflow_o, underflow_o, invalid_o, inexact_o}),
                  64'(sb[0].flg));
      end
    end
    acc = vi && ready_o;
    if (acc) begin
      e.a = a; e.b = b; e.res = expv[31:0]; e.flg = expv[35:32]; e.acc = cyc;
      sb.push_back(e);
    end
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    int budget;
    budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      drive_cycle(1'b0, 32'd0, 32'd0, 1'b1, 36'd0, acc);
      budget--;
    end
    if (sb.size() > 0) check_val("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (6) drive_cycle(1'b0, 32'd0, 32'd0, 1'b1, 36'd0, acc);
  endtask

  logic [31:0] dir_a[8]  = '{32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h7F000000,
                             32'h00800000, 32'h3F800001, 32'h00400000, 32'h3F800000};
  logic [31:0] dir_b[8]  = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h7F000000,
                             32'h00800000, 32'h3F800001, 32'h40000000, 32'hBF800000};
  logic [35:0] dir_e[8]  = '{{4'b0000, 32'h40400000}, {4'b0010, 32'h7FC00000},
                             {4'b0000, 32'hFF800000}, {4'b1001, 32'h7F800000},
                             {4'b0101, 32'h00000000}, {4'b0001, 32'h3F800002},
                             {4'b0000, 32'h00000000}, {4'b0000, 32'hBF800000}};

  initial begin
    logic        acc;
    logic [31:0] pa, pb;
    bit          pend;
    int          idx, k, pops0;
    logic [31:0] sa[6], sbv[6];

    rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; op_a_i = '0; op_b_i = '0;
    #3;
    check_val("rst_valid_o", 64'(valid_o), 64'd0);
    check_val("rst_res_o", 64'(res_o), 64'd0);
    check_val("rst_flags", 64'({overflow_o, underflow_o, invalid_o, inexact_o}), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check_val("rst_ready_o", 64'(ready_o), 64'd1);

    // Directed vectors, back to back, never stalled.
    chk_lat = 1;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, dir_a[i], dir_b[i], 1'b1, dir_e[i], acc);
    drain();

    // Six back-to-back operations with the consumer stalled in cycles 5-7.
    chk_lat = 0;
    for (int i = 0; i < 6; i++) begin
      sa[i] = {1'b0, 8'd127 + 8'(i), 23'($urandom)};
      sbv[i] = {1'(i), 8'd126, 23'($urandom)};
    end
    pops0 = n_pop; idx = 0; k = 1;
    while (idx < 6 && k < 40) begin
      drive_cycle(1'b1, sa[idx], sbv[idx], !(k >= 5 && k <= 7), model(sa[idx], sbv[idx]), acc);
      if (k >= 5 && k <= 7) check_val("stall_ready_o", 64'(ready_o), 64'd0);
      if (acc) idx++;
      k++;
    end
    drain();
    check_val("stall_count", 64'(n_pop - pops0), 64'd6);

    // Random traffic with random backpressure; upstream holds an offered pair.
    pend = 0; pa = '0; pb = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pa = rand_op(); pb = rand_op(); pend = 1;
      end
      drive_cycle(pend, pa, pb, $urandom_range(0, 3) != 0, model(pa, pb), acc);
      if (acc) pend = 0;
    end
    drain();

    // Reset with three operations in flight and the output stalled.
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, dir_a[0], dir_b[0], 1'b1, dir_e[0], acc);
    repeat (2) drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 36'd0, acc);
    #1;
    valid_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check_val("async_rst_valid_o", 64'(valid_o), 64'd0);
    check_val("async_rst_res_o", 64'(res_o), 64'd0);
    check_val("async_rst_ready_o", 64'(ready_o), 64'd1);
    sb.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    chk_lat = 1;
    pops0 = n_pop;
    drive_cycle(1'b1, 32'h40400000, 32'h40000000, 1'b1, {4'b0000, 32'h40C00000}, acc);
    drain();
    check_val("post_rst_count", 64'(n_pop - pops0), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iob_fp_mul_stream.md
IOB_FP_MUL_STREAM -- requirements
Module: iob_fp_mul_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, total float width.
REQ-002 SHALL have parameter EXP_W, default 8, exponent width; fraction width F = DATA_W-EXP_W-1, bias = 2^(EXP_W-1)-1.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port valid_i  input  1  operand pair present.
REQ-006 SHALL have port ready_o  output  1  block accepts the operand pair this cycle.
REQ-007 SHALL have port op_a_i  input  DATA_W  operand A, IEEE-754 layout {sign, exp, fraction}.
REQ-008 SHALL have port op_b_i  input  DATA_W  operand B, same layout.
REQ-009 SHALL have port valid_o  output  1  result present.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port res_o  output  DATA_W  product.
REQ-012 SHALL have ports overflow_o, underflow_o, invalid_o, inexact_o  output  1 each  flags belonging to res_o, meaningful only while valid_o=1.

Function
REQ-013 SHALL be a 4-stage pipeline, one valid bit per stage: unpack/classify, mantissa multiply plus exponent add, normalise, round/pack into output registers.
REQ-014 SHALL use one global advance enable: en = !valid_o | ready_i. ready_o = en.
- Input is accepted on a cycle with valid_i & ready_o.
- All stages shift together only when en=1.
- When en=0, every stage holds its data and valid bit.
REQ-015 SHALL have a latency of exactly 4 cycles, accept-to-valid_o, when no stall occurs. Throughput SHALL be 1 result/cycle. Results SHALL leave in acceptance order.
REQ-016 SHALL hold res_o and all flags stable while valid_o=1 and ready_i=0.
REQ-017 SHALL compute sign = sign_a XOR sign_b for every non-NaN result.
REQ-018 SHALL compute the exponent in signed EXP_W+2 bits as ea+eb-bias, +1 when the (F+1)x(F+1) product's MSB is set. The exponent SHALL never wrap.
REQ-019 SHALL round the normalised mantissa to nearest, ties to even, using guard, round and sticky bits. Sticky = OR of all discarded product bits.
REQ-020 SHALL renormalise after rounding: mantissa carry-out increments the exponent.
REQ-021 SHALL set inexact_o when any discarded bit is nonzero.
REQ-022 SHALL treat subnormal inputs as signed zero (flush-to-zero).
REQ-023 SHALL apply special cases with this priority:
- NaN operand -> canonical NaN {0, all-ones exp, 1, zeros}, invalid_o=1.
- inf x zero -> canonical NaN, invalid_o=1.
- inf x (nonzero or inf) -> inf with computed sign.
- zero x finite -> zero with computed sign.
- Special-case results SHALL carry no other flags.
REQ-024 SHALL handle overflow: final exponent >= 2^EXP_W-1 -> inf with computed sign, overflow_o=1, inexact_o=1.
REQ-025 SHALL handle underflow: final exponent <= 0 -> zero with computed sign, underflow_o=1, inexact_o=1. Subnormal results are never produced.
REQ-026 SHALL route special-case results through the same 4 stages as normal results, so latency is uniform.
REQ-027 SHALL keep flags aligned with the result they describe, including during stalls.
REQ-028 SHALL ignore valid_i while ready_o=0. The upstream holds its operands.

Reset
REQ-029 SHALL, while rst_n_i=0, clear all stage valid bits, valid_o, res_o, and all flags to 0, regardless of clk_i.
REQ-030 SHALL discard all in-flight operations on reset, including mid-pipeline and during a stall. The first result after reset SHALL come from the first post-reset acceptance.
REQ-031 SHALL drive ready_o=1 after reset, because valid_o=0.

Verification
REQ-032 0x3FC00000 x 0x40000000, ready_i=1 -> 0x40400000 valid exactly 4 cycles after acceptance, all flags 0.
REQ-033 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid_o=1. 0xFF800000 x 0x40000000 -> 0xFF800000, no flags.
REQ-034 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow_o=1, inexact_o=1. 0x00800000 x 0x00800000 -> 0x00000000, underflow_o=1, inexact_o=1.
REQ-035 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact_o=1. 0x00400000 x 0x40000000 -> 0x00000000 (flushed input), no flags.
REQ-036 6 back-to-back inputs with ready_i low for cycles 5-7 -> ready_o low on those cycles, all 6 results in order, none lost or duplicated, res_o stable while stalled.
REQ-037 rst_n_i pulsed low with 3 operations in flight -> valid_o=0 immediately. A new operation after reset yields only its own result, 4 cycles later.
